// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and byte-enable helper for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_RSVD} mem_size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
  function automatic logic [3:0] lane_mask(mem_size_e size, logic [1:0] lo);
    return size == MEM_B ? 4'b0001 << lo :
           size == MEM_H ? (lo[1] ? 4'b1100 : 4'b0011) :
           size == MEM_W ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: valid/ready request-response bus between load/store initiator and responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store lane replication/byte enables and load lane extraction with extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic [1:0]  lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    wdata_o = size_i == MEM_B ? {4{wdata_i[7:0]}} : size_i == MEM_H ? {2{wdata_i[15:0]}} : wdata_i;
    be_o    = lane_mask(size_i, lo_i);
    b       = rword_i[8*lo_i +: 8];
    h       = lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    rdata_o = size_i == MEM_B ? {{24{~unsigned_i & b[7]}}, b} :
              size_i == MEM_H ? {{16{~unsigned_i & h[15]}}, h} : rword_i;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle valid/ready data-memory slave with wait states and lane handling.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses instead of masking the low bits.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam bit BYPASS = WAIT_CYCLES == 0;
  dmem_state_e state_q;
  logic [3:0]  cnt_q;
  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  mem_size_e   size_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic        a_we, a_uns, a_mis, a_err, do_acc, wr_en;
  logic [31:0] a_addr, a_wdata, off, wr_data, rd_ext;
  mem_size_e   a_size;
  logic [1:0]  lo;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  // With zero wait states the access happens on the accept edge, straight from the bus
  always_comb begin
    a_we    = BYPASS ? bus.req_we : we_q;
    a_uns   = BYPASS ? bus.req_unsigned : uns_q;
    a_addr  = BYPASS ? bus.req_addr : addr_q;
    a_wdata = BYPASS ? bus.req_wdata : wdata_q;
    a_size  = BYPASS ? mem_size_e'(bus.req_size) : size_q;
    off     = a_addr - BASE_ADDR;
    idx     = off[AW+1:2];
`ifdef DMEM_MISALIGN_ERR_EN
    lo      = a_addr[1:0];
    a_mis   = (a_size == MEM_H && a_addr[0]) || (a_size == MEM_W && a_addr[1:0] != 2'b00);
`else
    lo      = a_size == MEM_H ? {a_addr[1], 1'b0} : a_size == MEM_W ? 2'b00 : a_addr[1:0];
    a_mis   = 1'b0;
`endif
    a_err   = a_size == MEM_RSVD || a_addr < BASE_ADDR || off >= 32'(DEPTH_WORDS * 4) || a_mis;
    do_acc  = rst_n && (BYPASS ? state_q == IDLE && bus.req_valid : state_q == WAIT && cnt_q == 4'd1);
    wr_en   = do_acc && a_we && !a_err;
  end
  dmem_lane_align u_align (
    .size_i    (a_size),
    .lo_i      (lo),
    .unsigned_i(a_uns),
    .wdata_i   (a_wdata),
    .rword_i   (mem[idx]),
    .wdata_o   (wr_data),
    .be_o      (be),
    .rdata_o   (rd_ext)
  );
  always_ff @(posedge clk)
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= MEM_B;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (do_acc) begin
      state_q     <= RESP;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= (a_we || a_err) ? '0 : rd_ext;
      rsp_err_q   <= a_err;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          we_q        <= bus.req_we;
          uns_q       <= bus.req_unsigned;
          addr_q      <= bus.req_addr;
          wdata_q     <= bus.req_wdata;
          size_q      <= mem_size_e'(bus.req_size);
          cnt_q       <= 4'(WAIT_CYCLES);
          state_q     <= WAIT;
          req_ready_q <= 1'b0;
        end
        WAIT: cnt_q <= cnt_q - 4'd1;
        RESP: if (bus.rsp_ready) begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with 2 and 4 wait states
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0, rst4_n = 1'b0;
  logic v = 1'b0, rr = 1'b0, sel = 1'b0, we = 1'b0, uns = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0] size = 2'b10;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dmem_responder_if b2 ();
  dmem_responder_if b4 ();
  dmem_responder #(.WAIT_CYCLES(2)) dut  (.clk(clk), .rst_n(rst_n),  .bus(b2));
  dmem_responder #(.WAIT_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(b4));
  assign b2.req_valid = v & ~sel;
  assign b4.req_valid = v & sel;
  assign b2.rsp_ready = rr & ~sel;
  assign b4.rsp_ready = rr & sel;
  assign b2.req_we = we;          assign b4.req_we = we;
  assign b2.req_addr = addr;      assign b4.req_addr = addr;
  assign b2.req_wdata = wdata;    assign b4.req_wdata = wdata;
  assign b2.req_size = size;      assign b4.req_size = size;
  assign b2.req_unsigned = uns;   assign b4.req_unsigned = uns;
  wire        qr = sel ? b4.req_ready : b2.req_ready;
  wire        rv = sel ? b4.rsp_valid : b2.rsp_valid;
  wire [31:0] rd = sel ? b4.rsp_rdata : b2.rsp_rdata;
  wire        er = sel ? b4.rsp_err : b2.rsp_err;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic u, input logic [31:0] exp_d, input logic exp_e,
                      input int exp_lat);
    int n;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(qr), 32'd1);
    we = w; addr = a; wdata = d; size = s; uns = u; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rv && n < 40);
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".rd"}, rd, exp_d);
    chk({tag, ".err"}, 32'(er), 32'(exp_e));
    rr = 1'b1;
    @(posedge clk);
    #1 rr = 1'b0;
    @(negedge clk);
    chk({tag, ".back"}, 32'(qr), 32'd1);
  endtask
  initial begin
    int n;
    logic seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", 32'(b2.req_ready), 32'd1);
    chk("rst.vld", 32'(b2.rsp_valid), 32'd0);
    chk("rst.rd", b2.rsp_rdata, 32'd0);
    chk("rst.err", 32'(b2.rsp_err), 32'd0);
    rst_n = 1'b1; rst4_n = 1'b1;
    xact("st_w",   1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 3);
    xact("ld_w",   0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0, 3);
    xact("st_w2",  1, 32'h10, 32'h11223344, 2'b10, 0, 32'h0, 0, 3);
    xact("st_b",   1, 32'h13, 32'h00000080, 2'b00, 0, 32'h0, 0, 3);
    xact("ld_w2",  0, 32'h10, 32'h0,        2'b10, 0, 32'h80223344, 0, 3);
    xact("ld_bs",  0, 32'h13, 32'h0,        2'b00, 0, 32'hFFFFFF80, 0, 3);
    xact("ld_bu",  0, 32'h13, 32'h0,        2'b00, 1, 32'h00000080, 0, 3);
    xact("ld_b1",  0, 32'h11, 32'h0,        2'b00, 1, 32'h00000033, 0, 3);
    xact("st_h",   1, 32'h22, 32'h0000A5A5, 2'b01, 0, 32'h0, 0, 3);
    xact("ld_hs",  0, 32'h22, 32'h0,        2'b01, 0, 32'hFFFFA5A5, 0, 3);
    xact("ld_hu",  0, 32'h22, 32'h0,        2'b01, 1, 32'h0000A5A5, 0, 3);
    // backpressure: response held, extra request ignored and not queued
    @(negedge clk);
    we = 0; addr = 32'h10; size = 2'b10; uns = 0; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rv && n < 40);
    chk("bp.lat", n, 3);
    addr = 32'h20; v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.vld", 32'(rv), 32'd1);
      chk("bp.rd", rd, 32'h80223344);
      chk("bp.rdy", 32'(qr), 32'd0);
    end
    v = 1'b0; rr = 1'b1;
    @(posedge clk);
    #1 rr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | rv;
    end
    chk("bp.noq", 32'(seen), 32'd0);
    xact("e_oob",  0, 32'h400, 32'h0,        2'b10, 0, 32'h0, 1, 3);
    xact("st_top", 1, 32'h3FC, 32'h0BADCAFE, 2'b10, 0, 32'h0, 0, 3);
    xact("ld_top", 0, 32'h3FC, 32'h0,        2'b10, 0, 32'h0BADCAFE, 0, 3);
    xact("e_rsvd", 0, 32'h10,  32'h0,        2'b11, 0, 32'h0, 1, 3);
    xact("e_rsst", 1, 32'h10,  32'hFFFFFFFF, 2'b11, 0, 32'h0, 1, 3);
    xact("ld_keep",0, 32'h10,  32'h0,        2'b10, 0, 32'h80223344, 0, 3);
    xact("st_w0",  1, 32'h00,  32'h01020304, 2'b10, 0, 32'h0, 0, 3);
`ifdef DMEM_MISALIGN_ERR_EN
    xact("mis_st", 1, 32'h02,  32'hCAFEF00D, 2'b10, 0, 32'h0, 1, 3);
    xact("mis_ld", 0, 32'h00,  32'h0,        2'b10, 0, 32'h01020304, 0, 3);
`else
    xact("mis_st", 1, 32'h02,  32'hCAFEF00D, 2'b10, 0, 32'h0, 0, 3);
    xact("mis_ld", 0, 32'h00,  32'h0,        2'b10, 0, 32'hCAFEF00D, 0, 3);
`endif
    sel = 1'b1;
    xact("w4_st",  1, 32'h40,  32'h55AA55AA, 2'b10, 0, 32'h0, 0, 5);
    xact("w4_ld",  0, 32'h40,  32'h0,        2'b10, 0, 32'h55AA55AA, 0, 5);
    @(negedge clk);
    we = 1; addr = 32'h40; wdata = 32'h12345678; size = 2'b10; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst4_n = 1'b0;
    #1;
    chk("mr.rdy", 32'(qr), 32'd1);
    chk("mr.vld", 32'(rv), 32'd0);
    chk("mr.rd", rd, 32'd0);
    chk("mr.err", 32'(er), 32'd0);
    repeat (2) @(negedge clk);
    rst4_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | rv;
    end
    chk("mr.norsp", 32'(seen), 32'd0);
    xact("mr_ld",  0, 32'h40,  32'h0,        2'b10, 0, 32'h55AA55AA, 0, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the RISC-V core's load/store port. It replaces the single-cycle combinational data memory with a valid/ready request–response slave. The slave has a programmable wait-state count, byte/halfword/word lane handling with load sign/zero extension, and error reporting. It sits between the core's memory-stage load/store initiator and a word-organised RAM array held inside this block.

## Interface
Parameters:
- `DEPTH_WORDS`, 256 — RAM depth in 32-bit words (power of two).
- `WAIT_CYCLES`, 1 — wait states between accept and response, 0..15.
- `BASE_ADDR`, 32'h0000_0000 — byte address of word 0.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — responder can accept a request.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size`  in  2  — 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  — load zero-extends when 1, sign-extends when 0.
- `rsp_valid`  out  1  — response present.
- `rsp_ready`  in  1  — initiator takes the response.
- `rsp_rdata`  out  32  — load data, extended; 0 for stores and for errors.
- `rsp_err`  out  1  — request faulted.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`: latch we/addr/wdata/size/unsigned.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or go straight to RESP when `WAIT_CYCLES` = 0.
- **WAIT**
  - Counter decrements each cycle.
  - When the counter reaches 1, perform the access and go to RESP.
- **Access step** (single cycle, on entry to RESP)
  - Compute `off = addr - BASE_ADDR`.
  - Word index = `off[log2(DEPTH_WORDS)+1:2]`.
  - Store: write only the selected byte lanes; byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - Load: register the lane-extracted, extended data into `rsp_rdata`.
- **RESP**
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` stay stable until `rsp_ready`.
  - On `rsp_ready`: go to IDLE.
- **Error conditions**
  - `req_size` = 11.
  - `off >= DEPTH_WORDS*4`, or `addr < BASE_ADDR`.
  - Misalignment, see Configuration.
- **On error:** no RAM write, `rsp_rdata` = 0, `rsp_err` = 1, same latency as a good access.
- Stores return a response with `rsp_rdata` = 0 (write acknowledge).
- RAM contents are not reset.

## Timing
- Accept at cycle N → `rsp_valid` high at cycle N+1+`WAIT_CYCLES`.
- `rsp_ready` high in the first RESP cycle → `req_ready` high at the next cycle; minimum turnaround is 2+`WAIT_CYCLES` cycles per request.
- `req_ready` is low in WAIT and RESP; `req_valid` in those states is ignored and not queued.
- `req_ready` is decoded from the state (no combinational path from `req_valid`).
- `rsp_valid` is registered, with no combinational path from `rsp_ready`.
- Reset values: state IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter = 0.
- **Reset mid-operation:** the transaction is dropped.
  - A store is committed only if the access-step clock edge occurred before `rst_n` fell.
  - No response is produced after reset.

## Configuration
- Macro: `DMEM_MISALIGN_ERR_EN`.
- **Defined:** half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0, is an error.
- **Undefined:** misaligned low address bits are masked before use (half ignores `addr[0]`, word ignores `addr[1:0]`), and no error is raised.

## Structure
- Package `dmem_pkg`:
  - `mem_size_e` (MEM_B, MEM_H, MEM_W, MEM_RSVD).
  - `dmem_state_e` (IDLE, WAIT, RESP).
  - Function `lane_mask(size, addr[1:0])` returning 4-bit byte enables.
- Sub-module `dmem_lane_align` (combinational):
  - Store direction: replicates the right-aligned store data onto the selected byte lanes and outputs the byte enables.
  - Load direction: extracts the selected lane from the read word and sign/zero-extends it.
- RAM: inferred `logic [31:0] mem [DEPTH_WORDS]` inside `dmem_responder`.

## Test plan
- **Word round-trip**, `WAIT_CYCLES` = 2: store word 0xDEADBEEF at 0x10, then load word 0x10 → `rsp_valid` 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
- **Byte store + signed/unsigned load:** store byte 0x80 at 0x13 over 0x11223344, then load word → 0x80223344. Load byte signed at 0x13 → 0xFFFFFF80; unsigned → 0x00000080.
- **Half loads:** store half 0xA5A5 at 0x22; load half signed at 0x22 → 0xFFFFA5A5; unsigned → 0x0000A5A5.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable, `req_ready` = 0, and a new `req_valid` is not accepted.
- **Errors:** load from `BASE_ADDR` + `DEPTH_WORDS`*4 → err 1, rdata 0. Size 11 → err 1. Word store to 0x02 → with the macro, err 1 and RAM unchanged; without it, writes word 0x00.
- **Reset mid-WAIT:** with `WAIT_CYCLES` = 4, accept a store, assert `rst_n` = 0 two cycles later → outputs at reset values, no response, target word unchanged.
